panel_entry_controller: RTL and testbench

- Front-panel sequencer for the Mock8080 board. It turns debounced button activity into edits of a 16-bit address register and an 8-bit data register.
- It writes the entered byte to memory through a req/ack handshake and then auto-advances the address.
- It sits between the debounce/monostable stage and the memory/display logic. It drives the field selector and display contents.

---
 rtl/panel_entry_controller_pkg.sv | 39 +++
 rtl/panel_autorepeat_stepper.sv | 72 +++++++
 rtl/panel_entry_controller.sv | 159 +++++++++++++++
 tb/tb_panel_entry_controller.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/panel_entry_controller_pkg.sv
// Shared definitions for the front-panel entry controller.
//   - Field encodings used on the field output and for byte selection.
//   - FSM state encoding (EDIT / WRITE).
//   - Default timing constants for auto-repeat and write acknowledge.
package panel_entry_controller_pkg;

  localparam logic [1:0] FIELD_ADDR_HI = 2'd0;
  localparam logic [1:0] FIELD_ADDR_LO = 2'd1;
  localparam logic [1:0] FIELD_DATA    = 2'd2;

  typedef enum logic {
    ST_EDIT  = 1'b0,
    ST_WRITE = 1'b1
  } state_e;

  localparam int unsigned DEF_REPEAT_DELAY = 25;
  localparam int unsigned DEF_REPEAT_RATE  = 5;
  localparam int unsigned DEF_ACK_TIMEOUT  = 255;

  // Field rotation ADDR_HI -> ADDR_LO -> DATA -> ADDR_HI. Encoding 3 is
  // never produced; if it ever appeared it falls back to ADDR_HI.
  function automatic logic [1:0] next_field(input logic [1:0] f);
    case (f)
      FIELD_ADDR_HI: next_field = FIELD_ADDR_LO;
      FIELD_ADDR_LO: next_field = FIELD_DATA;
      default:       next_field = FIELD_ADDR_HI;
    endcase
  endfunction

  // +1 / -1 on one byte with natural 8-bit wrap.
  function automatic logic [7:0] step_byte(input logic [7:0] b,
                                           input logic       up,
                                           input logic       dn);
    if (up)      step_byte = b + 8'd1;
    else if (dn) step_byte = b - 8'd1;
    else         step_byte = b;
  endfunction

endpackage

// File: rtl/panel_autorepeat_stepper.sv
// Auto-repeat step generator for one front-panel button.
//   qzt_clk : system clock
//   reset   : synchronous, active-low reset
//   tick    : one-cycle timing strobe pacing the repeat
//   level   : debounced button level
//   inhibit : forces no steps and a cleared counter (both buttons held)
//   step    : one-cycle step pulse, valid in the same cycle as its cause
// A press steps immediately; after REPEAT_DELAY ticks held it steps again,
// then every REPEAT_RATE ticks until released.
module panel_autorepeat_stepper
  import panel_entry_controller_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic qzt_clk,
  input  logic reset,
  input  logic tick,
  input  logic level,
  input  logic inhibit,
  output logic step
);

  localparam logic [7:0] DELAY_CNT = 8'(REPEAT_DELAY);
  localparam logic [7:0] RATE_CNT  = 8'(REPEAT_RATE);

  logic       level_q;
  logic [7:0] cnt_q, cnt_d;
  logic       rpt_q, rpt_d;   // 0: waiting out the initial delay, 1: repeating
  logic       fire;
  logic [7:0] limit;

  assign limit = rpt_q ? RATE_CNT : DELAY_CNT;

  // NOTE: every variable gets a default before any branch, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    rpt_d = rpt_q;
    fire  = 1'b0;
    // Released, freshly pressed or inhibited: the repeat sequence restarts.
    if (inhibit || !level || !level_q) begin
      cnt_d = '0;
      rpt_d = 1'b0;
    end else if (tick) begin
      if (cnt_q + 8'd1 == limit) begin
        fire  = 1'b1;
        cnt_d = '0;
        rpt_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  assign step = !inhibit && ((level && !level_q) || fire);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge qzt_clk) begin
    if (!reset) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
      rpt_q   <= 1'b0;
    end else begin
      level_q <= level;
      cnt_q   <= cnt_d;
      rpt_q   <= rpt_d;
    end
  end

endmodule

// File: rtl/panel_entry_controller.sv
// Front-panel sequencer: edits a 16-bit address and 8-bit data byte from
// button activity, writes the byte via a req/ack handshake, then advances
// the address.
//   qzt_clk, reset             : clock, synchronous active-low reset
//   tick                       : auto-repeat pacing strobe
//   up_level, down_level       : debounced step buttons
//   next_pulse, commit_pulse   : field select / write strobes
//   wr_ack                     : memory acknowledge
//   addr, data, field          : edit registers and selected field
//   wr_req, busy, wr_error     : write handshake, WRITE indicator, timeout flag
module panel_entry_controller
  import panel_entry_controller_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter int unsigned ACK_TIMEOUT  = DEF_ACK_TIMEOUT
) (
  input  logic        qzt_clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        up_level,
  input  logic        down_level,
  input  logic        next_pulse,
  input  logic        commit_pulse,
  input  logic        wr_ack,
  output logic [15:0] addr,
  output logic [7:0]  data,
  output logic [1:0]  field,
  output logic        wr_req,
  output logic        busy,
  output logic        wr_error
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(ACK_TIMEOUT);

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [1:0]  field_q, field_d;
  logic        wr_req_q, wr_req_d;
  logic        busy_q, busy_d;
  logic        wr_error_q, wr_error_d;
  logic [7:0]  tmo_q, tmo_d;

  logic inhibit, up_step, down_step;

  // Both buttons held cancels stepping in both directions.
  assign inhibit = up_level & down_level;

  panel_autorepeat_stepper #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_up_stepper (
    .qzt_clk (qzt_clk),
    .reset   (reset),
    .tick    (tick),
    .level   (up_level),
    .inhibit (inhibit),
    .step    (up_step)
  );

  panel_autorepeat_stepper #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_down_stepper (
    .qzt_clk (qzt_clk),
    .reset   (reset),
    .tick    (tick),
    .level   (down_level),
    .inhibit (inhibit),
    .step    (down_step)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    field_d    = field_q;
    wr_req_d   = wr_req_q;
    busy_d     = busy_q;
    wr_error_d = wr_error_q;
    tmo_d      = tmo_q;

    case (state_q)
      ST_EDIT: begin
        if (commit_pulse) begin
          // Commit outranks a simultaneous next_pulse or step.
          state_d    = ST_WRITE;
          wr_req_d   = 1'b1;
          busy_d     = 1'b1;
          wr_error_d = 1'b0;
          tmo_d      = '0;
        end else begin
          if (next_pulse) begin
            field_d    = next_field(field_q);
            wr_error_d = 1'b0;
          end
          // Steps land on the currently selected byte only; no carry between
          // the address halves.
          case (field_q)
            FIELD_ADDR_HI: addr_d[15:8] = step_byte(addr_q[15:8], up_step, down_step);
            FIELD_ADDR_LO: addr_d[7:0]  = step_byte(addr_q[7:0], up_step, down_step);
            FIELD_DATA:    data_d       = step_byte(data_q, up_step, down_step);
            default:       ;
          endcase
        end
      end

      ST_WRITE: begin
        if (wr_ack) begin
          state_d  = ST_EDIT;
          wr_req_d = 1'b0;
          busy_d   = 1'b0;
          addr_d   = addr_q + 16'd1;
          field_d  = FIELD_DATA;
        end else if (tmo_q == TIMEOUT_CNT) begin
          state_d    = ST_EDIT;
          wr_req_d   = 1'b0;
          busy_d     = 1'b0;
          wr_error_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end

      default: state_d = ST_EDIT;
    endcase
  end

  always_ff @(posedge qzt_clk) begin
    if (!reset) begin
      state_q    <= ST_EDIT;
      addr_q     <= '0;
      data_q     <= '0;
      field_q    <= FIELD_ADDR_HI;
      wr_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_error_q <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      field_q    <= field_d;
      wr_req_q   <= wr_req_d;
      busy_q     <= busy_d;
      wr_error_q <= wr_error_d;
      tmo_q      <= tmo_d;
    end
  end

  assign addr     = addr_q;
  assign data     = data_q;
  assign field    = field_q;
  assign wr_req   = wr_req_q;
  assign busy     = busy_q;
  assign wr_error = wr_error_q;

endmodule

// File: tb/tb_panel_entry_controller.sv
// Scoreboard bench for panel_entry_controller (REPEAT_DELAY=3, REPEAT_RATE=2,
// ACK_TIMEOUT=8). Stimulus pushes expected state snapshots and expected write
// transactions; a monitor on the falling edge pops and compares them.
module tb_panel_entry_controller;

  logic        qzt_clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick = 1'b0;
  logic        up_level = 1'b0;
  logic        down_level = 1'b0;
  logic        next_pulse = 1'b0;
  logic        commit_pulse = 1'b0;
  logic        wr_ack = 1'b0;
  logic [15:0] addr;
  logic [7:0]  data;
  logic [1:0]  field;
  logic        wr_req;
  logic        busy;
  logic        wr_error;

  always #5 qzt_clk = ~qzt_clk;

  panel_entry_controller #(
    .REPEAT_DELAY (3),
    .REPEAT_RATE  (2),
    .ACK_TIMEOUT  (8)
  ) dut (
    .qzt_clk      (qzt_clk),
    .reset        (reset),
    .tick         (tick),
    .up_level     (up_level),
    .down_level   (down_level),
    .next_pulse   (next_pulse),
    .commit_pulse (commit_pulse),
    .wr_ack       (wr_ack),
    .addr         (addr),
    .data         (data),
    .field        (field),
    .wr_req       (wr_req),
    .busy         (busy),
    .wr_error     (wr_error)
  );

  typedef struct {
    string       name;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [1:0]  field;
    logic        wr_req;
    logic        busy;
    logic        wr_error;
  } snap_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  snap_t snap_q[$];
  wr_t   wr_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic expect_state(input string name, input logic [15:0] a, input logic [7:0] d,
                              input logic [1:0] f, input logic r, input logic b, input logic e);
    snap_t s;
    s.name = name; s.addr = a; s.data = d; s.field = f;
    s.wr_req = r; s.busy = b; s.wr_error = e;
    snap_q.push_back(s);
  endtask

  task automatic expect_write(input logic [15:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    wr_q.push_back(w);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge qzt_clk);
    #1;
  endtask

  task automatic press_up();
    up_level = 1'b1; cyc(1); up_level = 1'b0; cyc(1);
  endtask

  task automatic press_down();
    down_level = 1'b1; cyc(1); down_level = 1'b0; cyc(1);
  endtask

  task automatic pulse_next();
    next_pulse = 1'b1; cyc(1); next_pulse = 1'b0;
  endtask

  task automatic tick_once();
    tick = 1'b1; cyc(1); tick = 1'b0; cyc(1);
  endtask

  // Monitor: compares snapshots and every rising wr_req against the queues.
  snap_t m_s;
  wr_t   m_w;
  logic  wr_req_prev = 1'b0;

  always @(negedge qzt_clk) begin
    if (snap_q.size() > 0) begin
      m_s = snap_q.pop_front();
      check({m_s.name, "_addr"},     32'(addr),     32'(m_s.addr));
      check({m_s.name, "_data"},     32'(data),     32'(m_s.data));
      check({m_s.name, "_field"},    32'(field),    32'(m_s.field));
      check({m_s.name, "_wr_req"},   32'(wr_req),   32'(m_s.wr_req));
      check({m_s.name, "_busy"},     32'(busy),     32'(m_s.busy));
      check({m_s.name, "_wr_error"}, 32'(wr_error), 32'(m_s.wr_error));
    end
    if (wr_req === 1'b1 && wr_req_prev !== 1'b1) begin
      if (wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=%0h data=%0h required none", addr, data);
      end else begin
        m_w = wr_q.pop_front();
        check("write_addr", 32'(addr), 32'(m_w.addr));
        check("write_data", 32'(data), 32'(m_w.data));
      end
    end
    wr_req_prev = wr_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset
    cyc(2);
    reset = 1'b1;
    expect_state("reset", 16'h0000, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);

    // UP on ADDR_HI, visible one cycle after the press
    up_level = 1'b1; cyc(1);
    expect_state("up_hi", 16'h0100, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    up_level = 1'b0; cyc(1);
    press_down();
    press_down();
    expect_state("down_wrap_hi", 16'hFF00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);

    // Field rotation and data wrap both ways
    pulse_next();
    expect_state("field_lo", 16'hFF00, 8'h00, 2'd1, 1'b0, 1'b0, 1'b0);
    pulse_next();
    expect_state("field_data", 16'hFF00, 8'h00, 2'd2, 1'b0, 1'b0, 1'b0);
    press_down();
    expect_state("data_ff", 16'hFF00, 8'hFF, 2'd2, 1'b0, 1'b0, 1'b0);
    press_up();
    expect_state("data_wrap", 16'hFF00, 8'h00, 2'd2, 1'b0, 1'b0, 1'b0);
    pulse_next();
    expect_state("field_wrap", 16'hFF00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    pulse_next();
    pulse_next();

    // Auto-repeat: steps at press, tick 3, 5, 7, 9
    up_level = 1'b1; cyc(1);
    expect_state("rpt_press", 16'hFF00, 8'h01, 2'd2, 1'b0, 1'b0, 1'b0);
    for (int t = 1; t <= 10; t++) begin
      tick = 1'b1; cyc(1); tick = 1'b0;
      if (t == 3) expect_state("rpt_tick3", 16'hFF00, 8'h02, 2'd2, 1'b0, 1'b0, 1'b0);
      cyc(1);
    end
    expect_state("rpt_10ticks", 16'hFF00, 8'h05, 2'd2, 1'b0, 1'b0, 1'b0);

    // Both held: no steps
    down_level = 1'b1; cyc(1);
    for (int t = 0; t < 6; t++) tick_once();
    expect_state("both_held", 16'hFF00, 8'h05, 2'd2, 1'b0, 1'b0, 1'b0);
    up_level = 1'b0; down_level = 1'b0; cyc(1);
    expect_state("both_release", 16'hFF00, 8'h05, 2'd2, 1'b0, 1'b0, 1'b0);

    // Build addr=FFFF, data=3C (press + 54 repeat steps over 109 ticks)
    pulse_next();
    pulse_next();
    press_down();
    pulse_next();
    expect_state("addr_ffff", 16'hFFFF, 8'h05, 2'd2, 1'b0, 1'b0, 1'b0);
    up_level = 1'b1; cyc(1);
    for (int t = 1; t <= 109; t++) tick_once();
    up_level = 1'b0; cyc(1);
    expect_state("data_3c", 16'hFFFF, 8'h3C, 2'd2, 1'b0, 1'b0, 1'b0);

    // Commit, ignored inputs during WRITE, ack after 4 cycles
    commit_pulse = 1'b1;
    expect_write(16'hFFFF, 8'h3C);
    cyc(1);
    commit_pulse = 1'b0;
    expect_state("commit", 16'hFFFF, 8'h3C, 2'd2, 1'b1, 1'b1, 1'b0);
    up_level = 1'b1; cyc(1);
    up_level = 1'b0; next_pulse = 1'b1; cyc(1);
    next_pulse = 1'b0; commit_pulse = 1'b1; cyc(1);
    commit_pulse = 1'b0; cyc(1);
    expect_state("write_frozen", 16'hFFFF, 8'h3C, 2'd2, 1'b1, 1'b1, 1'b0);
    wr_ack = 1'b1; cyc(1); wr_ack = 1'b0;
    expect_state("ack_done", 16'h0000, 8'h3C, 2'd2, 1'b0, 1'b0, 1'b0);

    // Stray ack in EDIT
    wr_ack = 1'b1; cyc(1); wr_ack = 1'b0;
    expect_state("stray_ack", 16'h0000, 8'h3C, 2'd2, 1'b0, 1'b0, 1'b0);

    // Timeout: wr_req high for 9 edges (counter 0..8) then abort
    commit_pulse = 1'b1;
    expect_write(16'h0000, 8'h3C);
    cyc(1);
    commit_pulse = 1'b0;
    expect_state("tmo_start", 16'h0000, 8'h3C, 2'd2, 1'b1, 1'b1, 1'b0);
    cyc(8);
    expect_state("tmo_last_high", 16'h0000, 8'h3C, 2'd2, 1'b1, 1'b1, 1'b0);
    cyc(1);
    expect_state("tmo_abort", 16'h0000, 8'h3C, 2'd2, 1'b0, 1'b0, 1'b1);

    // Next commit clears wr_error; reset mid-WRITE
    commit_pulse = 1'b1;
    expect_write(16'h0000, 8'h3C);
    cyc(1);
    commit_pulse = 1'b0;
    expect_state("err_cleared", 16'h0000, 8'h3C, 2'd2, 1'b1, 1'b1, 1'b0);
    cyc(2);
    reset = 1'b0; cyc(1);
    expect_state("reset_mid_write", 16'h0000, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1; wr_ack = 1'b1; cyc(1); wr_ack = 1'b0;
    expect_state("late_ack", 16'h0000, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);

    // next_pulse and commit_pulse together: commit wins
    next_pulse = 1'b1; commit_pulse = 1'b1;
    expect_write(16'h0000, 8'h00);
    cyc(1);
    next_pulse = 1'b0; commit_pulse = 1'b0;
    expect_state("commit_wins", 16'h0000, 8'h00, 2'd0, 1'b1, 1'b1, 1'b0);
    wr_ack = 1'b1; cyc(1); wr_ack = 1'b0;
    expect_state("ack_advance", 16'h0001, 8'h00, 2'd2, 1'b0, 1'b0, 1'b0);

    cyc(3);
    check("writes_seen", 32'(wr_q.size()), 32'd0);
    check("snaps_seen", 32'(snap_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
